id_ex_stage: RTL and testbench

//  ID/EX pipeline register and operand-forwarding stage. Latches decoded ID fields each cycle and

---
 rtl/id_ex_stage_if.sv | 88 ++++++++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
//   Bundles every non-clock/reset signal of the ID/EX stage. Signal names keep
//   the direction suffix as seen from the stage itself (_i = into the stage,
//   _o = out of the stage).
//
//   modport master : upstream/downstream pipeline logic (drives ID fields,
//                    forwarding sources and stall/flush; receives ALU inputs)
//   modport slave  : the id_ex_stage itself
//
//   Groups:
//     control    : stall_i, flush_i, hazard_o
//     ID fields  : id_valid_i, id_alu_ctrl_i, id_rs1_i, id_rs2_i, id_use_rs1_i,
//                  id_use_rs2_i, id_rd_i, id_rs1_data_i, id_rs2_data_i,
//                  id_imm_i, id_pc_i, id_asel_pc_i, id_bsel_imm_i,
//                  id_regwrite_i, id_memread_i, id_memwrite_i
//     forwarding : exm_rd_i, exm_regwrite_i, exm_result_i,
//                  wb_rd_i, wb_regwrite_i, wb_data_i
//     EX outputs : ex_valid_o, alu_ctrl_o, op_A_o, op_B_o, store_data_o,
//                  ex_rd_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) ();
  // control
  logic              stall_i;
  logic              flush_i;
  logic              hazard_o;
  // decoded ID fields
  logic              id_valid_i;
  logic [3:0]        id_alu_ctrl_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [XLEN-1:0]   id_pc_i;
  logic              id_asel_pc_i;
  logic              id_bsel_imm_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              id_memwrite_i;
  // forwarding sources
  logic [REG_AW-1:0] exm_rd_i;
  logic              exm_regwrite_i;
  logic [XLEN-1:0]   exm_result_i;
  logic [REG_AW-1:0] wb_rd_i;
  logic              wb_regwrite_i;
  logic [XLEN-1:0]   wb_data_i;
  // EX stage outputs
  logic              ex_valid_o;
  logic [3:0]        alu_ctrl_o;
  logic [XLEN-1:0]   op_A_o;
  logic [XLEN-1:0]   op_B_o;
  logic [XLEN-1:0]   store_data_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic              ex_regwrite_o;
  logic              ex_memread_o;
  logic              ex_memwrite_o;

  modport master (
    output stall_i, flush_i,
    output id_valid_i, id_alu_ctrl_i, id_rs1_i, id_rs2_i, id_use_rs1_i,
           id_use_rs2_i, id_rd_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_pc_i, id_asel_pc_i, id_bsel_imm_i, id_regwrite_i,
           id_memread_i, id_memwrite_i,
    output exm_rd_i, exm_regwrite_i, exm_result_i,
           wb_rd_i, wb_regwrite_i, wb_data_i,
    input  hazard_o, ex_valid_o, alu_ctrl_o, op_A_o, op_B_o, store_data_o,
           ex_rd_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o
  );

  modport slave (
    input  stall_i, flush_i,
    input  id_valid_i, id_alu_ctrl_i, id_rs1_i, id_rs2_i, id_use_rs1_i,
           id_use_rs2_i, id_rd_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
           id_pc_i, id_asel_pc_i, id_bsel_imm_i, id_regwrite_i,
           id_memread_i, id_memwrite_i,
    input  exm_rd_i, exm_regwrite_i, exm_result_i,
           wb_rd_i, wb_regwrite_i, wb_data_i,
    output hazard_o, ex_valid_o, alu_ctrl_o, op_A_o, op_B_o, store_data_o,
           ex_rd_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with operand forwarding and load-use detection.
//   Decoded ID fields are captured on each rising edge; the ALU operands are
//   then formed combinationally from the registered fields, with EX/MEM and
//   MEM/WB results bypassed in front of the registered regfile data.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (state returns to a bubble)
//     bus   : id_ex_stage_if.slave -- stall/flush control, ID fields,
//             forwarding sources, hazard request and EX-side outputs
//
//   Register update priority on each edge:
//     reset > stall (hold) > flush (bubble) > load-use hazard (bubble)
//           > invalid ID (bubble) > capture ID fields
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  // ALU op code for ADD; a bubble carries this so the ALU sees a benign op.
  localparam logic [3:0] ALU_ADD = 4'h0;

  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic              asel_pc;
    logic              bsel_imm;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } ex_t;

  // valid (MSB) = 0, alu_ctrl = ADD, everything else zero.
  localparam ex_t BUBBLE = ex_t'({1'b0, ALU_ADD, {($bits(ex_t) - 5){1'b0}}});

  ex_t  ex_q;
  ex_t  ex_d;
  logic hazard;

  // ---------------------------------------------------------------------------
  // Load-use detection: the load in EX has not produced its data yet, so a
  // dependent instruction in ID must wait one cycle. A flushed ID slot is
  // about to die anyway and must not stall the front end.
  // ---------------------------------------------------------------------------
  logic rs1_dep;
  logic rs2_dep;

  assign rs1_dep = bus.id_use_rs1_i && (bus.id_rs1_i == ex_q.rd);
  assign rs2_dep = bus.id_use_rs2_i && (bus.id_rs2_i == ex_q.rd);

  assign hazard = ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                  (rs1_dep || rs2_dep) && bus.id_valid_i && !bus.flush_i;

  // ---------------------------------------------------------------------------
  // Next-state selection
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_d = ex_q;
    if (!bus.stall_i) begin
      if (bus.flush_i || hazard || !bus.id_valid_i) begin
        ex_d = BUBBLE;
      end else begin
        ex_d.valid    = 1'b1;
        ex_d.alu_ctrl = bus.id_alu_ctrl_i;
        ex_d.rs1      = bus.id_rs1_i;
        ex_d.rs2      = bus.id_rs2_i;
        ex_d.rd       = bus.id_rd_i;
        ex_d.rs1_data = bus.id_rs1_data_i;
        ex_d.rs2_data = bus.id_rs2_data_i;
        ex_d.imm      = bus.id_imm_i;
        ex_d.pc       = bus.id_pc_i;
        ex_d.asel_pc  = bus.id_asel_pc_i;
        ex_d.bsel_imm = bus.id_bsel_imm_i;
        ex_d.regwrite = bus.id_regwrite_i;
        ex_d.memread  = bus.id_memread_i;
        ex_d.memwrite = bus.id_memwrite_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding: index 0 = rs1, index 1 = rs2. The youngest producer (EX/MEM)
  // wins over MEM/WB. x0 is never bypassed, so a read of x0 always returns the
  // registered regfile value (which is zero).
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] src_idx [2];
  logic [XLEN-1:0]   src_reg [2];
  logic [XLEN-1:0]   src_fwd [2];

  assign src_idx[0] = ex_q.rs1;
  assign src_idx[1] = ex_q.rs2;
  assign src_reg[0] = ex_q.rs1_data;
  assign src_reg[1] = ex_q.rs2_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_exm;
      logic hit_wb;
      assign hit_exm = bus.exm_regwrite_i && (bus.exm_rd_i != '0) &&
                       (bus.exm_rd_i == src_idx[gi]);
      assign hit_wb  = bus.wb_regwrite_i && (bus.wb_rd_i != '0) &&
                       (bus.wb_rd_i == src_idx[gi]);
      assign src_fwd[gi] = hit_exm ? bus.exm_result_i :
                           hit_wb  ? bus.wb_data_i    : src_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.hazard_o      = hazard;
  assign bus.ex_valid_o    = ex_q.valid;
  assign bus.alu_ctrl_o    = ex_q.alu_ctrl;
  assign bus.op_A_o        = ex_q.asel_pc  ? ex_q.pc  : src_fwd[0];
  assign bus.op_B_o        = ex_q.bsel_imm ? ex_q.imm : src_fwd[1];
  assign bus.store_data_o  = src_fwd[1];
  assign bus.ex_rd_o       = ex_q.rd;
  // Side-effect strobes are qualified so a bubble can never write or access memory.
  assign bus.ex_regwrite_o = ex_q.valid && ex_q.regwrite;
  assign bus.ex_memread_o  = ex_q.valid && ex_q.memread;
  assign bus.ex_memwrite_o = ex_q.valid && ex_q.memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        stall, flush, valid;
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2;
    logic [31:0] d1, d2, imm, pc;
    logic        asel, bsel, rw, mr, mw;
    logic [4:0]  exm_rd;
    logic        exm_rw;
    logic [31:0] exm_res;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic [31:0] wb_data;
  } in_t;

  typedef struct {
    in_t         in;
    logic        hz, v;
    logic [3:0]  alu;
    logic [31:0] a, b, sd;
    logic        rw, mr, mw;
  } vec_t;

  // Contents of the EX slot as the reference model sees it: the instruction
  // that was accepted, or "nothing" (bubble).
  typedef struct {
    logic        valid;
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic        asel, bsel, rw, mr, mw;
  } slot_t;

  int checks = 0;
  int errors = 0;

  vec_t  tbl [12];
  slot_t slot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic valid, input logic [3:0] alu,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic use1, input logic use2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [31:0] pc,
                             input logic asel, input logic bsel,
                             input logic rw, input logic mr, input logic mw);
    in_t x;
    x.stall = 0; x.flush = 0; x.valid = valid; x.alu = alu;
    x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.use1 = use1; x.use2 = use2;
    x.d1 = d1; x.d2 = d2; x.imm = imm; x.pc = pc;
    x.asel = asel; x.bsel = bsel; x.rw = rw; x.mr = mr; x.mw = mw;
    x.exm_rd = 0; x.exm_rw = 0; x.exm_res = 0;
    x.wb_rd = 0; x.wb_rw = 0; x.wb_data = 0;
    return x;
  endfunction

  function automatic in_t fw(input in_t x, input logic [4:0] erd, input logic erw,
                             input logic [31:0] eres, input logic [4:0] wrd,
                             input logic wrw, input logic [31:0] wdat);
    in_t y = x;
    y.exm_rd = erd; y.exm_rw = erw; y.exm_res = eres;
    y.wb_rd = wrd; y.wb_rw = wrw; y.wb_data = wdat;
    return y;
  endfunction

  function automatic in_t ctl(input in_t x, input logic stall, input logic flush);
    in_t y = x;
    y.stall = stall; y.flush = flush;
    return y;
  endfunction

  task automatic set_row(input int i, input in_t x, input logic hz, input logic v,
                         input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic rw, input logic mr, input logic mw);
    tbl[i].in = x; tbl[i].hz = hz; tbl[i].v = v; tbl[i].alu = alu;
    tbl[i].a = a; tbl[i].b = b; tbl[i].sd = sd;
    tbl[i].rw = rw; tbl[i].mr = mr; tbl[i].mw = mw;
  endtask

  task automatic drive(input in_t x);
    bus.stall_i = x.stall;          bus.flush_i = x.flush;
    bus.id_valid_i = x.valid;       bus.id_alu_ctrl_i = x.alu;
    bus.id_rs1_i = x.rs1;           bus.id_rs2_i = x.rs2;
    bus.id_use_rs1_i = x.use1;      bus.id_use_rs2_i = x.use2;
    bus.id_rd_i = x.rd;
    bus.id_rs1_data_i = x.d1;       bus.id_rs2_data_i = x.d2;
    bus.id_imm_i = x.imm;           bus.id_pc_i = x.pc;
    bus.id_asel_pc_i = x.asel;      bus.id_bsel_imm_i = x.bsel;
    bus.id_regwrite_i = x.rw;       bus.id_memread_i = x.mr;
    bus.id_memwrite_i = x.mw;
    bus.exm_rd_i = x.exm_rd;        bus.exm_regwrite_i = x.exm_rw;
    bus.exm_result_i = x.exm_res;
    bus.wb_rd_i = x.wb_rd;          bus.wb_regwrite_i = x.wb_rw;
    bus.wb_data_i = x.wb_data;
  endtask

  // ---------------- reference model ----------------
  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.alu = 4'h0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
    s.d1 = 0; s.d2 = 0; s.imm = 0; s.pc = 0;
    s.asel = 0; s.bsel = 0; s.rw = 0; s.mr = 0; s.mw = 0;
    return s;
  endfunction

  // Value the instruction in EX should see for register r: newest writer first.
  function automatic logic [31:0] operand(input in_t x, input logic [4:0] r, input logic [31:0] regval);
    if (r == 0) return regval;
    if (x.exm_rw && x.exm_rd == r) return x.exm_res;
    if (x.wb_rw && x.wb_rd == r) return x.wb_data;
    return regval;
  endfunction

  function automatic logic load_use(input slot_t s, input in_t x);
    if (!(s.valid && s.mr) || s.rd == 0 || !x.valid || x.flush) return 0;
    return (x.use1 && x.rs1 == s.rd) || (x.use2 && x.rs2 == s.rd);
  endfunction

  function automatic slot_t advance(input slot_t s, input in_t x);
    slot_t n;
    if (x.stall) return s;
    if (x.flush || load_use(s, x) || !x.valid) return empty_slot();
    n.valid = 1; n.alu = x.alu; n.rs1 = x.rs1; n.rs2 = x.rs2; n.rd = x.rd;
    n.d1 = x.d1; n.d2 = x.d2; n.imm = x.imm; n.pc = x.pc;
    n.asel = x.asel; n.bsel = x.bsel; n.rw = x.rw; n.mr = x.mr; n.mw = x.mw;
    return n;
  endfunction

  task automatic check_model(input in_t x);
    logic [31:0] a_src, b_src;
    a_src = operand(x, slot.rs1, slot.d1);
    b_src = operand(x, slot.rs2, slot.d2);
    chk("rnd hazard",   {31'd0, bus.hazard_o},      {31'd0, load_use(slot, x)});
    chk("rnd valid",    {31'd0, bus.ex_valid_o},    {31'd0, slot.valid});
    chk("rnd alu",      {28'd0, bus.alu_ctrl_o},    {28'd0, slot.alu});
    chk("rnd opA",      bus.op_A_o,                 slot.asel ? slot.pc : a_src);
    chk("rnd opB",      bus.op_B_o,                 slot.bsel ? slot.imm : b_src);
    chk("rnd store",    bus.store_data_o,           b_src);
    chk("rnd rd",       {27'd0, bus.ex_rd_o},       {27'd0, slot.rd});
    chk("rnd regwrite", {31'd0, bus.ex_regwrite_o}, {31'd0, slot.valid & slot.rw});
    chk("rnd memread",  {31'd0, bus.ex_memread_o},  {31'd0, slot.valid & slot.mr});
    chk("rnd memwrite", {31'd0, bus.ex_memwrite_o}, {31'd0, slot.valid & slot.mw});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    in_t idle, add_a, sub_b, lw_c, add_d, x0i, auipc, sw_e, tmp;

    idle  = mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_a = mk(1, 4'h0, 1, 2, 3, 1, 1, 5, 7, 0, 32'h100, 0, 0, 1, 0, 0);
    sub_b = mk(1, 4'h1, 1, 2, 6, 1, 1, 9, 3, 0, 32'h104, 0, 0, 1, 0, 0);
    lw_c  = mk(1, 4'h0, 1, 0, 4, 1, 0, 100, 0, 8, 32'h108, 0, 1, 1, 1, 0);
    add_d = mk(1, 4'h0, 4, 4, 5, 1, 1, 0, 0, 0, 32'h10C, 0, 0, 1, 0, 0);
    x0i   = mk(1, 4'h8, 0, 0, 7, 1, 1, 0, 0, 0, 32'h110, 0, 0, 1, 0, 0);
    auipc = mk(1, 4'h0, 2, 0, 9, 0, 0, 0, 0, 32'h2000, 32'h1000, 1, 1, 1, 0, 0);
    sw_e  = mk(1, 4'h0, 1, 2, 0, 1, 1, 32'h50, 32'h60, 4, 32'h118, 0, 1, 0, 0, 1);

    //            inputs                                              hz v alu  opA     opB     store   rw mr mw
    set_row(0,  add_a,                                                 0, 0, 0, 0,      0,      0,      0, 0, 0);
    set_row(1,  sub_b,                                                 0, 1, 0, 5,      7,      7,      1, 0, 0);
    set_row(2,  fw(lw_c, 1, 1, 32'h10, 1, 1, 32'h20),                  0, 1, 1, 32'h10, 3,      3,      1, 0, 0);
    set_row(3,  add_d,                                                 1, 1, 0, 100,    8,      0,      1, 1, 0);
    tmp = add_d; tmp.d1 = 32'h33; tmp.d2 = 32'h33;
    set_row(4,  fw(tmp, 0, 0, 0, 4, 1, 32'h44),                        0, 0, 0, 0,      0,      0,      0, 0, 0);
    set_row(5,  ctl(fw(x0i, 0, 0, 0, 4, 1, 32'h44), 0, 1),             0, 1, 0, 32'h44, 32'h44, 32'h44, 1, 0, 0);
    set_row(6,  fw(x0i, 0, 1, 32'hFF, 0, 0, 0),                        0, 0, 0, 0,      0,      0,      0, 0, 0);
    set_row(7,  fw(auipc, 0, 1, 32'hFF, 0, 1, 32'hEE),                 0, 1, 8, 0,      0,      0,      1, 0, 0);
    set_row(8,  ctl(fw(sw_e, 2, 1, 32'h77, 0, 0, 0), 1, 1),            0, 1, 0, 32'h1000, 32'h2000, 0,  1, 0, 0);
    set_row(9,  sw_e,                                                  0, 1, 0, 32'h1000, 32'h2000, 0,  1, 0, 0);
    set_row(10, idle,                                                  0, 1, 0, 32'h50, 4,      32'h60, 0, 0, 1);
    set_row(11, idle,                                                  0, 0, 0, 0,      0,      0,      0, 0, 0);

    drive(idle);
    do_reset();

    // ---------------- directed table ----------------
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].in);
      #2;
      chk($sformatf("row%0d hazard", i),   {31'd0, bus.hazard_o},      {31'd0, tbl[i].hz});
      chk($sformatf("row%0d valid", i),    {31'd0, bus.ex_valid_o},    {31'd0, tbl[i].v});
      chk($sformatf("row%0d alu", i),      {28'd0, bus.alu_ctrl_o},    {28'd0, tbl[i].alu});
      chk($sformatf("row%0d opA", i),      bus.op_A_o,                 tbl[i].a);
      chk($sformatf("row%0d opB", i),      bus.op_B_o,                 tbl[i].b);
      chk($sformatf("row%0d store", i),    bus.store_data_o,           tbl[i].sd);
      chk($sformatf("row%0d regwrite", i), {31'd0, bus.ex_regwrite_o}, {31'd0, tbl[i].rw});
      chk($sformatf("row%0d memread", i),  {31'd0, bus.ex_memread_o},  {31'd0, tbl[i].mr});
      chk($sformatf("row%0d memwrite", i), {31'd0, bus.ex_memwrite_o}, {31'd0, tbl[i].mw});
      $display("row %0d: hz=%0b v=%0b alu=%0h A=%08h B=%08h", i, bus.hazard_o,
               bus.ex_valid_o, bus.alu_ctrl_o, bus.op_A_o, bus.op_B_o);
    end

    // ---------------- randomized run against the model ----------------
    drive(idle);
    do_reset();
    slot = empty_slot();
    for (int n = 0; n < 400; n++) begin
      in_t r;
      @(negedge clk);
      r.stall  = ($urandom_range(0, 99) < 15);
      r.flush  = ($urandom_range(0, 99) < 10);
      r.valid  = ($urandom_range(0, 99) < 85);
      r.alu    = 4'($urandom_range(0, 15));
      r.rs1    = 5'($urandom_range(0, 3));
      r.rs2    = 5'($urandom_range(0, 3));
      r.rd     = 5'($urandom_range(0, 3));
      r.use1   = 1'($urandom_range(0, 1));
      r.use2   = 1'($urandom_range(0, 1));
      r.d1     = $urandom;  r.d2 = $urandom;
      r.imm    = $urandom;  r.pc = $urandom;
      r.asel   = 1'($urandom_range(0, 1));
      r.bsel   = 1'($urandom_range(0, 1));
      r.rw     = 1'($urandom_range(0, 1));
      r.mr     = ($urandom_range(0, 99) < 40);
      r.mw     = 1'($urandom_range(0, 1));
      r.exm_rd = 5'($urandom_range(0, 3));
      r.exm_rw = 1'($urandom_range(0, 1));
      r.exm_res = $urandom;
      r.wb_rd  = 5'($urandom_range(0, 3));
      r.wb_rw  = 1'($urandom_range(0, 1));
      r.wb_data = $urandom;
      drive(r);
      #2;
      check_model(r);
      $display("rnd %0d: st=%0b fl=%0b idv=%0b hz=%0b v=%0b A=%08h B=%08h", n, r.stall,
               r.flush, r.valid, bus.hazard_o, bus.ex_valid_o, bus.op_A_o, bus.op_B_o);
      slot = advance(slot, r);
    end

    // ---------------- asynchronous reset mid-stream ----------------
    @(negedge clk);
    tmp = mk(1, 4'h5, 1, 2, 3, 1, 1, 32'h11, 32'h22, 0, 32'h200, 0, 0, 1, 0, 1);
    drive(tmp);
    @(negedge clk);
    drive(fw(idle, 1, 1, 32'h99, 2, 1, 32'h98));
    #2;
    chk("pre-reset valid", {31'd0, bus.ex_valid_o}, 32'd1);
    chk("pre-reset opA", bus.op_A_o, 32'h99);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset valid",    {31'd0, bus.ex_valid_o},    32'd0);
    chk("async reset alu",      {28'd0, bus.alu_ctrl_o},    32'd0);
    chk("async reset opA",      bus.op_A_o,                 32'd0);
    chk("async reset opB",      bus.op_B_o,                 32'd0);
    chk("async reset regwrite", {31'd0, bus.ex_regwrite_o}, 32'd0);
    chk("async reset memwrite", {31'd0, bus.ex_memwrite_o}, 32'd0);
    $display("async reset: v=%0b alu=%0h A=%08h B=%08h", bus.ex_valid_o, bus.alu_ctrl_o,
             bus.op_A_o, bus.op_B_o);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
